// File: rtl/dm_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } dm_state_e;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;
  localparam int unsigned DM_AW      = 10;
  localparam int unsigned DM_DW      = 32;

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational 2-way grant selector: round-robin on ties, or fixed port-0 priority.
module dm_rr_pick import dm_pkg::*; #(
  parameter int unsigned PRIO_MODE = PRIO_RR
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_idx_o   = 1'b0;
    if (req0_i && req1_i) begin
      gnt_idx_o = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~last_grant_i;
    end else if (req1_i) begin
      gnt_idx_o = 1'b1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates CPU (port 0) and DMA/loader (port 1) onto the single-ported data memory.
module dm_arbiter import dm_pkg::*; #(
  parameter int unsigned PRIO_MODE = PRIO_RR,
  parameter int unsigned DW        = DM_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             we0,
  input  logic             bmode0,
  input  logic [11:0]      addr0,
  input  logic [DW-1:0]    wdata0,
  output logic [DW-1:0]    rdata0,
  output logic             ack0,
  output logic             err0,
  input  logic             req1,
  input  logic             we1,
  input  logic             bmode1,
  input  logic [11:0]      addr1,
  input  logic [DW-1:0]    wdata1,
  output logic [DW-1:0]    rdata1,
  output logic             ack1,
  output logic             err1,
  output logic [DM_AW-1:0] dm_addr,
  output logic [DW-1:0]    dm_din,
  output logic             dm_we,
  output logic             dm_bmode,
  output logic [1:0]       dm_bsel,
  input  logic [DW-1:0]    dm_dout
);

  dm_state_e state_q;
  logic last_grant_q;
  logic cmd_idx_q, cmd_we_q, cmd_mis_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic ack0_q, ack1_q, err0_q, err1_q;
  logic [DM_AW-1:0] dm_addr_q;
  logic [DW-1:0] dm_din_q;
  logic dm_we_q, dm_bmode_q;
  logic [1:0] dm_bsel_q;

  logic gnt_valid, gnt_idx;
  logic sel_we, sel_bmode, sel_mis;
  logic [11:0] sel_addr;
  logic [DW-1:0] sel_wdata, rd_val;

  dm_rr_pick #(
    .PRIO_MODE(PRIO_MODE)
  ) u_pick (
    .req0_i      (req0),
    .req1_i      (req1),
    .last_grant_i(last_grant_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign sel_we    = gnt_idx ? we1    : we0;
  assign sel_bmode = gnt_idx ? bmode1 : bmode0;
  assign sel_addr  = gnt_idx ? addr1  : addr0;
  assign sel_wdata = gnt_idx ? wdata1 : wdata0;
  // A word access must be 4-byte aligned; byte accesses can never misalign.
  assign sel_mis   = ~sel_bmode & (sel_addr[1:0] != 2'b00);
  assign rd_val    = (cmd_we_q | cmd_mis_q) ? '0 : dm_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cmd_idx_q    <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_mis_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      dm_addr_q    <= '0;
      dm_din_q     <= '0;
      dm_we_q      <= 1'b0;
      dm_bmode_q   <= 1'b0;
      dm_bsel_q    <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            cmd_idx_q  <= gnt_idx;
            cmd_we_q   <= sel_we;
            cmd_mis_q  <= sel_mis;
            dm_addr_q  <= sel_addr[11:2];
            dm_bsel_q  <= sel_addr[1:0];
            dm_bmode_q <= sel_bmode;
            dm_din_q   <= sel_wdata;
            dm_we_q    <= sel_we & ~sel_mis;
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          // Memory commits the write on this edge; the strobe must not outlive it.
          dm_we_q      <= 1'b0;
          last_grant_q <= cmd_idx_q;
          if (cmd_idx_q) begin
            rdata1_q <= rd_val;
            ack1_q   <= 1'b1;
            err1_q   <= cmd_mis_q;
          end else begin
            rdata0_q <= rd_val;
            ack0_q   <= 1'b1;
            err0_q   <= cmd_mis_q;
          end
          state_q <= StDone;
        end
        StDone: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign dm_addr  = dm_addr_q;
  assign dm_din   = dm_din_q;
  assign dm_we    = dm_we_q;
  assign dm_bmode = dm_bmode_q;
  assign dm_bsel  = dm_bsel_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench: instance 0 round-robin, instance 1 fixed priority, each with a memory model.
module tb_dm_arbiter;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [9:0]  addr;
    logic [1:0]  bsel;
    logic        bmode;
    logic [31:0] din;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0[2], we0[2], bmode0[2], req1[2], we1[2], bmode1[2];
  logic [11:0] addr0[2], addr1[2];
  logic [31:0] wdata0[2], wdata1[2], rdata0[2], rdata1[2], dm_din[2], dm_dout[2];
  logic ack0[2], ack1[2], err0[2], err1[2], dm_we[2], dm_bmode[2];
  logic [9:0] dm_addr[2];
  logic [1:0] dm_bsel[2];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_n = 0;
  bit chk_fair = 1'b0;
  exp_t exp_q[4][$];
  int ord[$];
  int ack_cyc[$];
  logic [7:0] ref_mem[2][4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, want);
    end
  endfunction

  function automatic void fail(string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no response within budget, required one", nm);
  endfunction

  // Reference model: byte-addressed memory, little-endian, applied in per-port issue order.
  function automatic void model(int i, int p, bit we, bit bm, logic [11:0] a, logic [31:0] wd);
    exp_t e;
    int base;
    bit mis;
    mis = !bm && (a % 4 != 0);
    base = (a / 4) * 4;
    e = '0;
    e.err = mis;
    e.we = we && !mis;
    e.addr = a[11:2];
    e.bsel = a[1:0];
    e.bmode = bm;
    e.din = wd;
    if (!mis) begin
      if (we) begin
        if (bm) ref_mem[i][a] = wd[7:0];
        else for (int k = 0; k < 4; k++) ref_mem[i][base + k] = wd[8*k +: 8];
      end else if (bm) begin
        e.rdata = {{24{ref_mem[i][a][7]}}, ref_mem[i][a]};
      end else begin
        e.rdata = {ref_mem[i][base+3], ref_mem[i][base+2], ref_mem[i][base+1], ref_mem[i][base]};
      end
    end
    exp_q[i*2 + p].push_back(e);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] mem [1024];
    logic [7:0] mbyte;
    int wcnt = 0;
    int p;
    exp_t e;

    dm_arbiter #(
      .PRIO_MODE(g)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0[g]),
      .we0     (we0[g]),
      .bmode0  (bmode0[g]),
      .addr0   (addr0[g]),
      .wdata0  (wdata0[g]),
      .rdata0  (rdata0[g]),
      .ack0    (ack0[g]),
      .err0    (err0[g]),
      .req1    (req1[g]),
      .we1     (we1[g]),
      .bmode1  (bmode1[g]),
      .addr1   (addr1[g]),
      .wdata1  (wdata1[g]),
      .rdata1  (rdata1[g]),
      .ack1    (ack1[g]),
      .err1    (err1[g]),
      .dm_addr (dm_addr[g]),
      .dm_din  (dm_din[g]),
      .dm_we   (dm_we[g]),
      .dm_bmode(dm_bmode[g]),
      .dm_bsel (dm_bsel[g]),
      .dm_dout (dm_dout[g])
    );

    initial for (int k = 0; k < 1024; k++) mem[k] = '0;

    always @(posedge clk) begin
      if (dm_we[g]) begin
        if (dm_bmode[g]) mem[dm_addr[g]][{dm_bsel[g], 3'b000} +: 8] <= dm_din[g][7:0];
        else mem[dm_addr[g]] <= dm_din[g];
      end
    end

    assign mbyte = mem[dm_addr[g]][{dm_bsel[g], 3'b000} +: 8];
    assign dm_dout[g] = dm_bmode[g] ? {{24{mbyte[7]}}, mbyte} : mem[dm_addr[g]];

    always @(negedge clk) begin
      if (!rst_n) begin
        wcnt = 0;
      end else begin
        if (dm_we[g]) wcnt++;
        if (ack0[g] || ack1[g]) begin
          p = ack1[g] ? 1 : 0;
          chk("ack_both", {31'b0, ack0[g] & ack1[g]}, 32'd0);
          chk("err_other", {31'b0, p != 0 ? err0[g] : err1[g]}, 32'd0);
          ord.push_back(p);
          ack_cyc.push_back(cyc_n);
          if (exp_q[g*2 + p].size() == 0) begin
            fail("unexpected_ack");
          end else begin
            e = exp_q[g*2 + p].pop_front();
            chk("rdata", p != 0 ? rdata1[g] : rdata0[g], e.rdata);
            chk("err", {31'b0, p != 0 ? err1[g] : err0[g]}, {31'b0, e.err});
            chk("we_cycles", wcnt, {31'b0, e.we});
            chk("dm_addr", {22'b0, dm_addr[g]}, {22'b0, e.addr});
            chk("dm_bsel", {30'b0, dm_bsel[g]}, {30'b0, e.bsel});
            chk("dm_bmode", {31'b0, dm_bmode[g]}, {31'b0, e.bmode});
            chk("dm_din", dm_din[g], e.din);
          end
          wcnt = 0;
        end
      end
    end
  end

  task automatic do_txn(int i, int p, bit we, bit bm, logic [11:0] a, logic [31:0] wd,
                        bit keep, int lat);
    int cyc = 0;
    bit got;
    model(i, p, we, bm, a, wd);
    if (p == 0) begin
      we0[i] = we; bmode0[i] = bm; addr0[i] = a; wdata0[i] = wd; req0[i] = 1'b1;
    end else begin
      we1[i] = we; bmode1[i] = bm; addr1[i] = a; wdata1[i] = wd; req1[i] = 1'b1;
    end
    do begin
      @(negedge clk);
      cyc++;
      got = (p == 0) ? ack0[i] : ack1[i];
    end while (!got && cyc < 40);
    if (!got) fail("ack_timeout");
    else begin
      if (lat != 0) chk("ack_latency", cyc, lat);
      if (chk_fair) chk("fair_wait_le6", {31'b0, cyc <= 6}, 32'd1);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (p == 0) req0[i] = 1'b0;
      else req1[i] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 0; we0[i] = 0; bmode0[i] = 0; addr0[i] = '0; wdata0[i] = '0;
      req1[i] = 0; we1[i] = 0; bmode1[i] = 0; addr1[i] = '0; wdata1[i] = '0;
      for (int k = 0; k < 4096; k++) ref_mem[i][k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", {30'b0, ack0[i], ack1[i]}, 32'd0);
      chk("rst_err", {30'b0, err0[i], err1[i]}, 32'd0);
      chk("rst_rdata0", rdata0[i], 32'd0);
      chk("rst_rdata1", rdata1[i], 32'd0);
      chk("rst_dm_ctl", {28'b0, dm_we[i], dm_bmode[i], dm_bsel[i]}, 32'd0);
      chk("rst_dm_addr", {22'b0, dm_addr[i]}, 32'd0);
      chk("rst_dm_din", dm_din[i], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word write/read, byte write, sign-extended byte read.
    do_txn(0, 0, 1, 0, 12'h010, 32'h12345678, 0, 3);
    do_txn(0, 0, 0, 0, 12'h010, 32'h0, 0, 3);
    do_txn(0, 1, 1, 1, 12'h013, 32'h00000080, 0, 3);
    do_txn(0, 1, 0, 0, 12'h010, 32'h0, 0, 3);
    do_txn(0, 1, 0, 1, 12'h013, 32'h0, 0, 3);

    // Misaligned word write is blocked.
    do_txn(0, 0, 1, 0, 12'h020, 32'hCAFEF00D, 0, 3);
    do_txn(0, 0, 1, 0, 12'h022, 32'hDEADBEEF, 0, 3);
    do_txn(0, 0, 0, 0, 12'h020, 32'h0, 0, 3);

    // Late request raised during port 0's ACCESS cycle.
    fork
      do_txn(0, 0, 0, 0, 12'h010, 32'h0, 0, 3);
      begin
        @(posedge clk);
        #1;
        do_txn(0, 1, 0, 1, 12'h012, 32'h0, 0, 5);
      end
    join

    // Reset during a write's ACCESS cycle; pending port 1 read served afterwards.
    we0[0] = 1; bmode0[0] = 0; addr0[0] = 12'h100; wdata0[0] = 32'hA5A5A5A5; req0[0] = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_access_we", {31'b0, dm_we[0]}, 32'd1);
    model(0, 1, 0, 0, 12'h100, 32'h0);
    we1[0] = 0; bmode1[0] = 0; addr1[0] = 12'h100; wdata1[0] = 32'h0; req1[0] = 1;
    #2 rst_n = 1'b0;
    req0[0] = 1'b0;
    #1;
    chk("rst_mid_we", {31'b0, dm_we[0]}, 32'd0);
    chk("rst_mid_ack", {30'b0, ack0[0], ack1[0]}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack1[0] && n < 20);
    chk("rst_resume_lat", n, 2);
    @(posedge clk);
    #1 req1[0] = 1'b0;

    // Continuous contention, round-robin.
    chk_fair = 1'b1;
    ord.delete();
    ack_cyc.delete();
    fork
      begin
        do_txn(0, 0, 1, 0, 12'h040, $urandom, 1, 0);
        do_txn(0, 0, 1, 0, 12'h044, $urandom, 0, 0);
      end
      begin
        do_txn(0, 1, 1, 0, 12'h840, $urandom, 1, 0);
        do_txn(0, 1, 1, 0, 12'h844, $urandom, 0, 0);
      end
    join
    chk("rr_count", ord.size(), 4);
    if (ord.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", ord[k], k % 2);
      for (int k = 1; k < 4; k++) chk("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 3);
    end

    // Fixed priority: port 0 re-requesting always wins.
    chk_fair = 1'b0;
    ord.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) do_txn(1, 0, 1, 0, 12'(16 + 4*k), $urandom, k < 3, 0);
      end
      do_txn(1, 1, 0, 0, 12'h010, 32'h0, 0, 0);
    join
    chk("fixed_count", ord.size(), 5);
    if (ord.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("fixed_order", ord[k], (k == 4) ? 1 : 0);
    end

    // Randomized traffic on disjoint per-port regions.
    chk_fair = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int mode;
      bit w0, b0, w1, b1;
      logic [11:0] a0, a1;
      mode = $urandom_range(0, 2);
      w0 = 1'($urandom); b0 = 1'($urandom); w1 = 1'($urandom); b1 = 1'($urandom);
      a0 = 12'($urandom_range(0, 63));
      a1 = 12'($urandom_range(12'h800, 12'h83F));
      if (!b0 && $urandom_range(0, 3) != 0) a0[1:0] = 2'b00;
      if (!b1 && $urandom_range(0, 3) != 0) a1[1:0] = 2'b00;
      if (mode == 0) do_txn(0, 0, w0, b0, a0, $urandom, 0, 3);
      else if (mode == 1) do_txn(0, 1, w1, b1, a1, $urandom, 0, 3);
      else begin
        fork
          do_txn(0, 0, w0, b0, a0, $urandom, 0, 0);
          do_txn(0, 1, w1, b1, a1, $urandom, 0, 0);
        join
      end
    end

    repeat (4) @(negedge clk);
    for (int q = 0; q < 4; q++) chk("queue_drained", exp_q[q].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter sharing the single 4 KB data memory between the CPU data port (port 0) and the DMA/debug loader (port 1).
- Accepts byte addresses with a req/ack handshake and drives the memory's word address, write data, write enable, byte-mode and byte-select inputs.
- Registers the read data and returns it with ack.
- Detects misaligned word accesses and blocks them.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- DW, 32, data width (fixed at the memory's word width).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held with its command until ack0.
- we0  in  1  port 0 write (1) / read (0).
- bmode0  in  1  port 0 byte access (1) / word access (0).
- addr0  in  12  port 0 byte address.
- wdata0  in  32  port 0 write data; byte mode uses [7:0].
- rdata0  out  32  port 0 read data; valid while ack0=1.
- ack0  out  1  port 0 one-cycle completion pulse.
- err0  out  1  port 0 misalign error; valid with ack0.
- req1, we1, bmode1, addr1, wdata1, rdata1, ack1, err1: same as port 0, for port 1.
- dm_addr  out  10  memory word address, addr[11:2] of the granted port.
- dm_din  out  32  memory write data.
- dm_we  out  1  memory write enable.
- dm_bmode  out  1  memory byte mode.
- dm_bsel  out  2  memory byte select, addr[1:0].
- dm_dout  in  32  memory combinational read data; byte mode returns sign-extended data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0: ack*, err*, rdata*, dm_we, dm_addr, dm_din, dm_bmode, dm_bsel.
  - Round-robin pointer last_grant is set to 1, so port 0 wins the first tie.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
  - Each transaction takes 3 cycles from the IDLE sample to the ack pulse.
- IDLE:
  - Samples req0/req1.
  - If neither is set, stay in IDLE.
  - If exactly one is set, grant that port.
  - If both are set: with PRIO_MODE=0, grant the port not equal to last_grant; with PRIO_MODE=1, grant port 0.
  - On a grant, latch grant index, we, bmode, addr and wdata into the command register, then go to ACCESS.
- ACCESS:
  - dm_addr, dm_bmode and dm_bsel are driven from the command register.
  - dm_din = wdata.
  - dm_we = we & ~mis, asserted for exactly this one cycle. The memory writes on the edge that leaves ACCESS.
  - mis = ~bmode & (addr[1:0] != 0).
  - Reads capture dm_dout into the rdata register of the granted port on the exit edge.
  - last_grant is updated to the granted port.
  - Next state is DONE.
- DONE:
  - ack of the granted port = 1 for one cycle; the other port's ack = 0.
  - err = mis.
  - rdata is held. On writes or misaligned accesses, rdata = 0.
  - Next state is IDLE.
- Outside ACCESS, dm_we = 0. dm_addr, dm_bmode, dm_bsel and dm_din hold their last values.
- Handshake rules:
  - A requester keeps req and its command stable until its ack.
  - It deasserts req on the edge after ack. A req still high in the following IDLE is a new transaction.
  - A req raised during ACCESS or DONE waits until the next IDLE. No request is ever dropped.
  - rdata is only guaranteed while ack=1.
- Misaligned word access: no memory write, err=1 with ack, rdata=0. Byte accesses never produce err.
- Fairness: with PRIO_MODE=0 and both ports requesting continuously, grants alternate 0,1,0,1. Each port waits at most 6 cycles.
- Reset mid-transaction: the transaction is aborted, dm_we drops immediately, and no ack is issued. A write whose edge had not yet occurred is lost.

Decomposition:
- Shared package dm_pkg holds:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - PRIO_RR=0, PRIO_FIXED=0... corrected: PRIO_RR=0, PRIO_FIXED=1.
  - DM_AW=10 and DM_DW=32.
- One natural sub-module: dm_rr_pick, the combinational 2-way grant selector taking req0, req1, last_grant and PRIO_MODE.
- The FSM, command register and response registers stay in dm_arbiter.

Test Plan:
- Single write then read: port 0 writes word 0x12345678 at addr 0x010, then reads it.
  - Required: ack0 in the 3rd cycle each time, rdata0=0x12345678, err0=0, dm_we high exactly 1 cycle with dm_addr=0x004.
- Byte write and sign-extended read: port 1 writes byte 0x80 at addr 0x013, then reads the word at 0x010 and the byte at 0x013.
  - Required: word = 0x80345678, byte read rdata1 = 0xFFFFFF80, dm_bsel=3.
- Contention: req0 and req1 both held for 4 transactions, PRIO_MODE=0.
  - Required grant order 0,1,0,1; one ack per 3 cycles.
  - Repeat with PRIO_MODE=1 and req0 re-raised every time: required grant order 0,0,0,0.
- Misalign: port 0 word write of 0xDEADBEEF at addr 0x022.
  - Required: err0=1 with ack0, dm_we never asserted, a later read of 0x020 returns the old value.
- Reset mid-operation: assert rst_n=0 while in ACCESS on a write.
  - Required: dm_we=0 and ack*=0 immediately, state IDLE after release, a pending req served next.
- Late request: req1 rises during port 0's ACCESS cycle.
  - Required: ack0 in DONE, port 1 granted at the next IDLE, ack1 three cycles later.
